// File: rtl/ret_int_fsm.sv
// RET / RTI / interrupt-entry sequencer: stalls decode, injects stack push/pop
// micro-ops, gathers popped words and finishes with a one-cycle PC redirect.
module ret_int_fsm #(
  parameter logic [15:0] POP_PC_HIGH_OP  = 16'b0110000000001010,
  parameter logic [15:0] POP_PC_LOW_OP   = 16'b0110000000001011,
  parameter logic [15:0] POP_FLAGS_OP    = 16'b0110000000001100,
  parameter logic [15:0] PUSH_PC_LOW_OP  = 16'b0110000000001000,
  parameter logic [15:0] PUSH_PC_HIGH_OP = 16'b0110000000001001,
  parameter logic [15:0] PUSH_FLAGS_OP   = 16'b0110000000001101,
  parameter logic [15:0] NOP_OP          = 16'h0000,
  parameter logic [31:0] INT_VECTOR      = 32'h0000_0002
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_ret,
  input  logic        i_rti,
  input  logic        i_int_req,
  input  logic        i_call_active,
  input  logic [31:0] i_pc_in,
  input  logic [3:0]  i_flags_in,
  input  logic        i_pop_valid,
  input  logic [15:0] i_pop_data,
  output logic [15:0] o_inj_op,
  output logic        o_inj_valid,
  output logic [15:0] o_inj_data,
  output logic        o_stall,
  output logic [31:0] o_pc_out,
  output logic        o_change_pc,
  output logic [3:0]  o_flags_out,
  output logic        o_flags_load,
  output logic        o_int_ack
);

  typedef enum logic [3:0] {
    S_IDLE, S_POP_HI, S_WAIT_HI, S_POP_LO, S_WAIT_LO, S_POP_FL, S_WAIT_FL,
    S_INT_FL, S_INT_LO, S_INT_HI, S_JUMP, S_INT_JUMP
  } state_t;

  state_t      r_state;
  logic        r_is_rti;
  logic [31:0] r_save_pc;
  logic [3:0]  r_save_flags;
  logic [15:0] r_inj_op;
  logic        r_inj_valid;
  logic [15:0] r_inj_data;
  logic        r_stall;
  logic [31:0] r_pc_out;
  logic        r_change_pc;
  logic [3:0]  r_flags_out;
  logic        r_flags_load;
  logic        r_int_ack;

  // Outputs are registered together with the next state, so each output
  // reflects the state being entered on this edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_is_rti     <= 1'b0;
      r_save_pc    <= '0;
      r_save_flags <= '0;
      r_inj_op     <= NOP_OP;
      r_inj_valid  <= 1'b0;
      r_inj_data   <= '0;
      r_stall      <= 1'b0;
      r_pc_out     <= '0;
      r_change_pc  <= 1'b0;
      r_flags_out  <= '0;
      r_flags_load <= 1'b0;
      r_int_ack    <= 1'b0;
    end else begin
      r_inj_op     <= NOP_OP;
      r_inj_valid  <= 1'b0;
      r_inj_data   <= '0;
      r_change_pc  <= 1'b0;
      r_flags_load <= 1'b0;
      r_int_ack    <= 1'b0;
      r_stall      <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (i_rti || i_ret) begin
            r_state     <= S_POP_HI;
            r_is_rti    <= i_rti;
            r_inj_op    <= POP_PC_HIGH_OP;
            r_inj_valid <= 1'b1;
          end else if (i_int_req && !i_call_active) begin
            r_state      <= S_INT_FL;
            r_save_pc    <= i_pc_in;
            r_save_flags <= i_flags_in;
            r_inj_op     <= PUSH_FLAGS_OP;
            r_inj_valid  <= 1'b1;
            r_inj_data   <= {12'b0, i_flags_in};
          end else begin
            r_stall <= 1'b0;
          end
        end
        S_POP_HI: r_state <= S_WAIT_HI;
        S_WAIT_HI: begin
          if (i_pop_valid) begin
            r_pc_out[31:16] <= i_pop_data;
            r_state         <= S_POP_LO;
            r_inj_op        <= POP_PC_LOW_OP;
            r_inj_valid     <= 1'b1;
          end
        end
        S_POP_LO: r_state <= S_WAIT_LO;
        S_WAIT_LO: begin
          if (i_pop_valid) begin
            r_pc_out[15:0] <= i_pop_data;
            if (r_is_rti) begin
              r_state     <= S_POP_FL;
              r_inj_op    <= POP_FLAGS_OP;
              r_inj_valid <= 1'b1;
            end else begin
              r_state     <= S_JUMP;
              r_change_pc <= 1'b1;
            end
          end
        end
        S_POP_FL: r_state <= S_WAIT_FL;
        S_WAIT_FL: begin
          if (i_pop_valid) begin
            r_flags_out  <= i_pop_data[3:0];
            r_flags_load <= 1'b1;
            r_state      <= S_JUMP;
            r_change_pc  <= 1'b1;
          end
        end
        // Push order flags, PC low, PC high leaves PC high on the stack top.
        S_INT_FL: begin
          r_state     <= S_INT_LO;
          r_inj_op    <= PUSH_PC_LOW_OP;
          r_inj_valid <= 1'b1;
          r_inj_data  <= r_save_pc[15:0];
        end
        S_INT_LO: begin
          r_state     <= S_INT_HI;
          r_inj_op    <= PUSH_PC_HIGH_OP;
          r_inj_valid <= 1'b1;
          r_inj_data  <= r_save_pc[31:16];
        end
        S_INT_HI: begin
          r_state     <= S_INT_JUMP;
          r_pc_out    <= INT_VECTOR;
          r_change_pc <= 1'b1;
          r_int_ack   <= 1'b1;
        end
        S_JUMP, S_INT_JUMP: begin
          r_state <= S_IDLE;
          r_stall <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_stall <= 1'b0;
        end
      endcase
    end
  end

  assign o_inj_op     = r_inj_op;
  assign o_inj_valid  = r_inj_valid;
  assign o_inj_data   = r_inj_data;
  assign o_stall      = r_stall;
  assign o_pc_out     = r_pc_out;
  assign o_change_pc  = r_change_pc;
  assign o_flags_out  = r_flags_out;
  assign o_flags_load = r_flags_load;
  assign o_int_ack    = r_int_ack;

endmodule

// File: doc/ret_int_fsm.md
Name: ret_int_fsm

Overview:
Sequencing controller for RET, RTI and hardware-interrupt entry; sits beside call_fsm at the decode stage.
- Stalls fetch/decode while it runs.
- Injects stack push/pop micro-ops into the pipeline.
- Collects popped words returned from the memory stage.
- Ends each sequence with a one-cycle PC redirect.

Parameters:
POP_PC_HIGH_OP, 16'b0110000000001010, injected op that pops the PC high half
POP_PC_LOW_OP, 16'b0110000000001011, injected op that pops the PC low half
POP_FLAGS_OP, 16'b0110000000001100, injected op that pops the flags
PUSH_PC_LOW_OP, 16'b0110000000001000, injected op that pushes the PC low half
PUSH_PC_HIGH_OP, 16'b0110000000001001, injected op that pushes the PC high half
PUSH_FLAGS_OP, 16'b0110000000001101, injected op that pushes the flags
NOP_OP, 16'h0000, op driven while nothing is injected
INT_VECTOR, 32'h0000_0002, interrupt handler address

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
ret  in  1  RET decoded this cycle
rti  in  1  RTI decoded this cycle
int_req  in  1  level interrupt request, held until int_ack
call_active  in  1  call_fsm sequence in progress; blocks interrupt entry
pc_in  in  32  PC of the next instruction, saved on interrupt
flags_in  in  4  current CCR (flags register), saved on interrupt
pop_valid  in  1  memory stage returns a popped word
pop_data  in  16  popped word
inj_op  out  16  injected micro-op
inj_valid  out  1  inj_op is valid this cycle
inj_data  out  16  value to push, qualifies push ops
stall  out  1  freeze fetch/decode
pc_out  out  32  redirect target
change_pc  out  1  one-cycle PC redirect strobe
flags_out  out  4  restored flags
flags_load  out  1  one-cycle strobe that loads flags_out into the CCR
int_ack  out  1  one-cycle interrupt acknowledge

Behaviour:
- Moore machine. All state and registers are cleared asynchronously when reset=0.
- Reset values: state IDLE; inj_op=NOP_OP; inj_valid=0; inj_data=0; stall=0; pc_out=0; change_pc=0; flags_out=0; flags_load=0; int_ack=0.
- States: IDLE, POP_HI, WAIT_HI, POP_LO, WAIT_LO, POP_FL, WAIT_FL, INT_FL, INT_LO, INT_HI, JUMP, INT_JUMP.
- IDLE priority, evaluated at the clock edge:
  - rti → POP_HI, with the RTI flag set.
  - else ret → POP_HI, with the RTI flag clear.
  - else (int_req & !call_active) → INT_FL; capture pc_in and flags_in into save registers.
  - ret and rti both high: treat as rti.
  - A pending interrupt is serviced after RET/RTI completes, provided int_req is still high.
- POP_x states: inj_op = matching pop op; inj_valid=1; stall=1. Next state is WAIT_x.
- WAIT_x states: inj_valid=0; stall=1. Hold until pop_valid=1, then:
  - WAIT_HI: pop_data → pc_out[31:16]; next POP_LO.
  - WAIT_LO: pop_data → pc_out[15:0]; next POP_FL if RTI, else JUMP.
  - WAIT_FL: pop_data[3:0] → flags_out; flags_load=1 on the following cycle; next JUMP.
- Interrupt push order is flags, PC low, PC high (stack top = PC high, matching call_fsm). Each push state lasts one cycle with inj_valid=1 and stall=1:
  - INT_FL: inj_op=PUSH_FLAGS_OP, inj_data={12'b0, saved flags}.
  - INT_LO: inj_op=PUSH_PC_LOW_OP, inj_data=saved PC[15:0].
  - INT_HI: inj_op=PUSH_PC_HIGH_OP, inj_data=saved PC[31:16].
- JUMP: change_pc=1, stall=1, pc_out stable; next IDLE.
- INT_JUMP: pc_out=INT_VECTOR, change_pc=1, int_ack=1, stall=1; next IDLE.
- Outside POP/INT states: inj_op=NOP_OP, inj_valid=0.
- pc_out holds its last value in IDLE.
- pop_valid outside WAIT states: ignored.
- ret, rti and int_req outside IDLE: ignored; no queuing except int_req, which is a level signal.
- RET latency with pop_valid one cycle after issue: ret sampled at edge 0; change_pc asserted in cycle 5; back in IDLE at cycle 6.
- Interrupt latency: int_ack and change_pc asserted 4 cycles after the request is sampled.
- Reset mid-sequence: sequence abandoned, all reset values restored, no redirect issued.

Test Plan:
1. Reset: reset=0 → inj_op=0, stall=0, pc_out=0, all strobes 0. Release reset → IDLE.
2. RET:
   - Stimulus: ret=1 for one cycle; pop_data 16'h1234 then 16'h5678, each returned one cycle after its pop op.
   - Response: inj_op=POP_PC_HIGH_OP then POP_PC_LOW_OP; stall=1 throughout; pc_out=32'h1234_5678 with change_pc=1 in cycle 5; stall=0 afterwards.
3. RTI:
   - Stimulus: pops return 16'h0000, 16'h0040, 16'h0005.
   - Response: pc_out=32'h0000_0040; flags_out=4'h5 with a one-cycle flags_load; change_pc=1 once.
4. Interrupt entry:
   - Stimulus: pc_in=32'h0001_00A0, flags_in=4'hA, int_req=1.
   - Response, pushes in order: PUSH_FLAGS_OP/16'h000A, PUSH_PC_LOW_OP/16'h00A0, PUSH_PC_HIGH_OP/16'h0001. Then pc_out=32'h2, change_pc=1, int_ack=1.
5. Priority:
   - ret and int_req both high → RET runs first, then the interrupt starts right after.
   - int_req with call_active=1 → no action until call_active=0.
6. Slow memory and reset:
   - pop_valid delayed 3 cycles → FSM holds in WAIT_HI with stall=1.
   - reset=0 during WAIT_LO → immediate return to IDLE, change_pc never asserted.
